// File: rtl/fir_ntap_if.sv
// Bus of the N-tap FIR: the sample stream with its valid, the coefficient write port, and the scaled output.
// Latency: none; this interface only carries signals.
// Backpressure: none; the consumer takes every out_valid pulse.
interface fir_ntap_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 3,
    parameter int OUT_W  = 8
);
    localparam int AW = $clog2(TAPS);

    logic              in_valid;
    logic [DATA_W-1:0] x;
    logic              clr;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [OUT_W-1:0]  y;
    logic              sat;

    modport master (
        output in_valid, x, clr, coef_we, coef_addr, coef_data,
        input  out_valid, y, sat
    );

    modport slave (
        input  in_valid, x, clr, coef_we, coef_addr, coef_data,
        output out_valid, y, sat
    );
endinterface

// File: rtl/fir_ntap.sv
// N-tap FIR with writable coefficients and output shift; FIR_SAT_EN selects clamping (sat flag) over wrap-around.
// Latency: 2 cycles from an accepted sample to out_valid/y, one sample per cycle.
// Backpressure: none; every out_valid pulse must be consumed. clr flushes history, rst also restores coefficients to 1.
module fir_ntap #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 3,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic      clk,
    input  logic      rst,
    fir_ntap_if.slave bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);

    logic [TAPS-2:0][DATA_W-1:0] d_q, d_d;
    logic [TAPS-1:0][COEF_W-1:0] c_q, c_d;
    logic [TAPS-1:0][PROD_W-1:0] p_q, p_d;
    logic                        v1_q, v1_d;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_W-1:0]            y_q, y_d;
    logic                        sat_q, sat_d;

    logic [TAPS-1:0][DATA_W-1:0] tap;
    logic [ACC_W-1:0]            acc;
    logic [OUT_W-1:0]            y_scaled;
    logic                        clamp;

    // tap[0] is the live sample, tap[k] the sample k accepted cycles ago
    assign tap = {d_q, bus.x};

    always_comb begin : accumulate
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + ACC_W'(p_q[k]);
        end
    end

    always_comb begin : scale
`ifdef FIR_SAT_EN
        clamp    = ((acc >> SHIFT) >> OUT_W) != '0;
        y_scaled = clamp ? '1 : OUT_W'(acc >> SHIFT);
`else
        clamp    = 1'b0;
        y_scaled = OUT_W'(acc >> SHIFT);
`endif
    end

    always_comb begin : next_state
        d_d         = d_q;
        c_d         = c_q;
        p_d         = p_q;
        v1_d        = 1'b0;
        out_valid_d = v1_q;
        y_d         = y_q;
        sat_d       = sat_q;

        // Products use the coefficients as they stood before any write on this same edge
        if (bus.in_valid) begin
            d_d  = tap[TAPS-2:0];
            v1_d = 1'b1;
            for (int k = 0; k < TAPS; k++) begin
                p_d[k] = PROD_W'(tap[k]) * PROD_W'(c_q[k]);
            end
        end

        if (v1_q) begin
            y_d   = y_scaled;
            sat_d = clamp;
        end

        if (bus.coef_we && (int'(bus.coef_addr) < TAPS)) begin
            c_d[bus.coef_addr] = bus.coef_data;
        end

        // Flush drops the concurrent sample and everything in flight, but leaves y/sat and coefficients alone
        if (bus.clr) begin
            d_d         = '0;
            p_d         = '0;
            v1_d        = 1'b0;
            out_valid_d = 1'b0;
            y_d         = y_q;
            sat_d       = sat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q         <= '0;
            c_q         <= {TAPS{COEF_W'(1)}};
            p_q         <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            d_q         <= d_d;
            c_q         <= c_d;
            p_q         <= p_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.sat       = sat_q;
endmodule

// File: doc/fir_ntap.md
# fir_ntap

Parametrised N-tap FIR filter, the successor to the fixed three-tap filter. It adds a configurable tap count and data/coefficient widths, runtime-writable coefficients, an input-valid/output-valid handshake, a two-stage pipeline and an output scaling shift. It sits in the same sample datapath as the three-tap block and consumes one sample per valid cycle. With default parameters and reset coefficients it reproduces the three-tap moving sum.

## Interface
Parameters:
- DATA_W, 8, input sample width (unsigned)
- COEF_W, 8, coefficient width (unsigned)
- TAPS, 3, number of taps (≥2)
- OUT_W, 8, output width
- SHIFT, 0, right shift applied to the accumulator before output

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  x is a valid sample this cycle
- x  in  DATA_W  input sample
- clr  in  1  synchronous flush of delay line and pipeline; coefficients kept
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index for the write; out-of-range writes are ignored
- coef_data  in  COEF_W  coefficient value
- out_valid  out  1  y is valid this cycle
- y  out  OUT_W  filtered, scaled output
- sat  out  1  y was clamped this sample (only with FIR_SAT_EN)

## Operation
- Delay line d[0..TAPS-2] holds past samples. Tap inputs: t[0]=x, t[k]=d[k-1].
- On an edge with in_valid=1: d[0]<=x and d[k]<=d[k-1]. In parallel, stage-1 products p[k]<=t[k]*c[k], using pre-shift tap values and pre-write coefficients. v1<=1.
- On an edge with in_valid=0: the delay line holds and v1<=0. Gaps do not insert zeros.
- Stage 2 on every edge: acc = Σp[k], width ACC_W = DATA_W+COEF_W+$clog2(TAPS). Then s = acc >> SHIFT (logical shift). y<=f(s), out_valid<=v1, sat<=clamp flag. y and sat update only when v1=1; otherwise they hold.
- Coefficient write: c[coef_addr]<=coef_data on the coef_we edge. A write in the same cycle as in_valid does not affect that sample. It applies from the next accepted sample.
- clr takes priority over in_valid: d, p, v1 and out_valid are zeroed, and the concurrent sample is dropped. Samples already in flight are discarded. Coefficients, y and sat are unchanged.
- Reset: d=0, p=0, v1=0, every c[k]=1, out_valid=0, y=0, sat=0. Reset takes priority over clr, coef_we and in_valid. A mid-stream reset discards all in-flight samples and restores the default coefficients.

## Timing
- Latency is 2 cycles. A sample accepted at edge n produces out_valid=1 and y after edge n+1.
- Throughput is 1 sample/cycle. There is no backpressure; the consumer must accept every out_valid.
- out_valid is a one-cycle pulse per accepted sample. Back-to-back in_valid gives continuous out_valid.
- The first TAPS-1 outputs after reset or clr include zero history.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- FIR_SAT_EN defined: if s > 2^OUT_W-1, then y = 2^OUT_W-1 and sat=1 for that sample. Otherwise y = s[OUT_W-1:0] and sat=0.
- FIR_SAT_EN undefined: y = s[OUT_W-1:0] (wrap-around truncation), and sat is tied to 0.

## Test plan
All scenarios use defaults (TAPS=3, SHIFT=0) unless stated.
- Moving sum: reset, then in_valid=1 on 8,3,23,1,69 on consecutive cycles -> y = 8,11,34,27,93, with out_valid starting 2 cycles after the first sample.
- Gaps: same samples with in_valid=0 for 2 cycles between 23 and 1 -> same y sequence, with out_valid low during the gap plus latency and no zero insertion.
- Coefficient write: write c[0]=2 in the same cycle as sample 23 of the sequence 8,3,23,1 -> y = 8,11,34,28. Sample 23 still uses c[0]=1, giving 34. Sample 1 uses c[0]=2, giving 2+23+3=28.
- Saturation: all c[k]=4, then x=200 for 3 samples:
  - with FIR_SAT_EN -> y = 255,255,255 and sat=1,1,1;
  - without it -> y = 32,64,96 and sat=0.
- Shift: c = {1,2,1}, SHIFT=2, constant x=100 -> third output y=100. Intermediate outputs are 25 and 75.
- clr/reset mid-stream:
  - clr asserted with in_valid after samples 8,3 -> no out_valid for the dropped sample or the in-flight ones, and the next sample 5 gives y=5;
  - rst mid-stream -> out_valid=0 and y=0 on the next cycle, and a prior write c[1]=7 is restored to 1.
